// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types for the MEM/WB boundary
package pipe_pkg;

    typedef enum logic [1:0] {
        ALU     = 2'b00,
        LOAD    = 2'b01,
        PC4     = 2'b10,
        ALU_ALT = 2'b11
    } resultsrc_t;

    // funct3 load encodings; unlisted codes are treated as full-word
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } addrmode_t;

    // Control half of the MEM/WB register; the XLEN-wide data fields sit beside it
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        resultsrc_t resultsrc;
        addrmode_t  addrmode;
        logic [4:0] rd;
    } mem_wb_t;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load byte/half selection, sign/zero extension and misalignment detect
module load_extend
    import pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  addrmode_t       addrmode,
    output logic [XLEN-1:0] result,
    output logic            misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result     = word;
        misaligned = 1'b0;
        case (addrmode)
            LB:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LBU: result = {{(XLEN-8){1'b0}}, byte_sel};
            LH: begin
                result     = {{(XLEN-16){half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            LHU: begin
                result     = {{(XLEN-16){1'b0}}, half_sel};
                misaligned = offset[0];
            end
            LW:      misaligned = (offset != 2'd0);
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB register, load extension and result select; WB_RETIRE_CNT_EN adds retire counter
module wb_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             enW,
    input  logic             flushW,
    input  logic             validM,
    input  logic             regwriteM,
    input  logic [1:0]       resultsrcM,
    input  logic [2:0]       addressingmodeM,
    input  logic [4:0]       rdM,
    input  logic [XLEN-1:0]  aluresultM,
    input  logic [XLEN-1:0]  readdataM,
    input  logic [XLEN-1:0]  pcplus4M,
    output logic             regwriteW,
    output logic [4:0]       rdW,
    output logic [XLEN-1:0]  resultW,
    output logic             validW,
    output logic             misalignW,
    output logic [CNT_W-1:0] instretW
);

    mem_wb_t         ctrl;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] pc4_q;

    always_ff @(posedge CLK) begin
        if (rst || flushW) begin
            ctrl    <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            pc4_q   <= '0;
        end else if (enW) begin
            ctrl    <= '{valid:     validM,
                         regwrite:  regwriteM,
                         resultsrc: resultsrc_t'(resultsrcM),
                         addrmode:  addrmode_t'(addressingmodeM),
                         rd:        rdM};
            alu_q   <= aluresultM;
            rdata_q <= readdataM;
            pc4_q   <= pcplus4M;
        end
    end

    logic [XLEN-1:0] load_val;
    logic            ext_mis;
    logic            mis;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .word       (rdata_q),
        .offset     (alu_q[1:0]),
        .addrmode   (ctrl.addrmode),
        .result     (load_val),
        .misaligned (ext_mis)
    );

    assign mis = (ctrl.resultsrc == LOAD) && ext_mis;

    always_comb begin
        case (ctrl.resultsrc)
            LOAD:    resultW = load_val;
            PC4:     resultW = pc4_q;
            default: resultW = alu_q;
        endcase
    end

    // A misaligned load must not write the register file; it is reported instead
    assign regwriteW = ctrl.valid && ctrl.regwrite && (ctrl.rd != 5'd0) && !mis;
    assign misalignW = ctrl.valid && mis;
    assign validW    = ctrl.valid;
    assign rdW       = ctrl.rd;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge CLK) begin
        if (rst) begin
            instret_q <= '0;
        end else if (validW && !misalignW) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign instretW = instret_q;
`else
    assign instretW = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed scoreboard bench for wb_stage
module tb_wb_stage;
    import pipe_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 64;

    logic             CLK = 1'b0;
    logic             rst = 1'b1;
    logic             enW = 1'b1;
    logic             flushW = 1'b0;
    logic             validM = 1'b0;
    logic             regwriteM = 1'b0;
    logic [1:0]       resultsrcM = '0;
    logic [2:0]       addressingmodeM = '0;
    logic [4:0]       rdM = '0;
    logic [XLEN-1:0]  aluresultM = '0;
    logic [XLEN-1:0]  readdataM = '0;
    logic [XLEN-1:0]  pcplus4M = '0;
    logic             regwriteW;
    logic [4:0]       rdW;
    logic [XLEN-1:0]  resultW;
    logic             validW;
    logic             misalignW;
    logic [CNT_W-1:0] instretW;

    wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .rst(rst), .enW(enW), .flushW(flushW),
        .validM(validM), .regwriteM(regwriteM), .resultsrcM(resultsrcM),
        .addressingmodeM(addressingmodeM), .rdM(rdM), .aluresultM(aluresultM),
        .readdataM(readdataM), .pcplus4M(pcplus4M),
        .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW), .validW(validW),
        .misalignW(misalignW), .instretW(instretW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        valid;
        logic        rw;
        logic        mis;
        logic [4:0]  rd;
        logic [31:0] res;
        bit          chk_data;
    } exp_t;

    exp_t        sb[$];
    exp_t        last;
    bit          cur_ok = 1'b0;
    logic [63:0] exp_cnt = '0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Clock one edge, track the retire count model, then compare the W slot at negedge
    task automatic edge_and_check(input string tag);
        exp_t e;
        @(posedge CLK);
`ifdef WB_RETIRE_CNT_EN
        if (rst) exp_cnt = '0;
        else if (cur_ok) exp_cnt = exp_cnt + 64'd1;
`endif
        cur_ok = sb[0].valid && !sb[0].mis;
        @(negedge CLK);
        e = sb.pop_front();
        chk({tag, ".validW"},    64'(validW),    64'(e.valid));
        chk({tag, ".regwriteW"}, 64'(regwriteW), 64'(e.rw));
        chk({tag, ".misalignW"}, 64'(misalignW), 64'(e.mis));
        if (e.chk_data) begin
            chk({tag, ".rdW"},     64'(rdW),     64'(e.rd));
            chk({tag, ".resultW"}, 64'(resultW), 64'(e.res));
        end
        chk({tag, ".instretW"}, instretW, exp_cnt);
        last = e;
    endtask

    task automatic send(input string tag, input logic v, input logic rw, input logic [1:0] rs,
                        input logic [2:0] am, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] rdata, input logic [31:0] pc4,
                        input logic [31:0] eres, input logic erw, input logic emis);
        exp_t e;
        enW = 1'b1; flushW = 1'b0;
        validM = v; regwriteM = rw; resultsrcM = rs; addressingmodeM = am;
        rdM = rd; aluresultM = alu; readdataM = rdata; pcplus4M = pc4;
        e = '{valid: v, rw: erw, mis: emis, rd: rd, res: eres, chk_data: 1'b1};
        sb.push_back(e);
        edge_and_check(tag);
    endtask

    task automatic randomize_m();
        validM = 1'($urandom); regwriteM = 1'($urandom);
        resultsrcM = 2'($urandom); addressingmodeM = 3'($urandom);
        rdM = 5'($urandom); aluresultM = $urandom; readdataM = $urandom; pcplus4M = $urandom;
    endtask

    task automatic reset_cycle(input string tag);
        exp_t e;
        rst = 1'b1; enW = 1'b1; flushW = 1'b0;
        randomize_m();
        e = '{valid: 1'b0, rw: 1'b0, mis: 1'b0, rd: 5'd0, res: 32'd0, chk_data: 1'b1};
        sb.push_back(e);
        edge_and_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge CLK);
        reset_cycle("rst0");
        reset_cycle("rst1");
        rst = 1'b0;

        //    tag     v  rw rs     am      rd     alu           rdata         pc4           exp_res       rw mis
        send("lb",   1, 1, 2'b01, 3'b000, 5'd5, 32'h0000_1003, 32'h80FF_1234, 32'h0,        32'hFFFF_FF80, 1, 0);
        send("lbu",  1, 1, 2'b01, 3'b100, 5'd5, 32'h0000_1003, 32'h80FF_1234, 32'h0,        32'h0000_0080, 1, 0);
        send("lh_mis",1,1, 2'b01, 3'b001, 5'd6, 32'h0000_1001, 32'h80FF_1234, 32'h0,        32'h0000_1234, 0, 1);
        send("lhu",  1, 1, 2'b01, 3'b101, 5'd6, 32'h0000_1002, 32'hBEEF_0000, 32'h0,        32'h0000_BEEF, 1, 0);
        send("jal",  1, 1, 2'b10, 3'b000, 5'd1, 32'h0000_2000, 32'h1111_1111, 32'h0000_0104, 32'h0000_0104, 1, 0);
        send("jal_x0",1,1, 2'b10, 3'b000, 5'd0, 32'h0000_2000, 32'h1111_1111, 32'h0000_0104, 32'h0000_0104, 0, 0);
        send("alu",  1, 1, 2'b00, 3'b010, 5'd7, 32'hDEAD_BEEF, 32'h2222_2222, 32'h0000_0200, 32'hDEAD_BEEF, 1, 0);
        send("alu11",1, 1, 2'b11, 3'b001, 5'd8, 32'h1234_5677, 32'h3333_3333, 32'h0000_0300, 32'h1234_5677, 1, 0);
        send("lw",   1, 1, 2'b01, 3'b010, 5'd9, 32'h0000_1000, 32'hCAFE_F00D, 32'h0,        32'hCAFE_F00D, 1, 0);
        send("lw_mis",1,1, 2'b01, 3'b010, 5'd9, 32'h0000_1002, 32'hCAFE_F00D, 32'h0,        32'hCAFE_F00D, 0, 1);
        send("lb_neg0",1,1,2'b01, 3'b000, 5'd10,32'h0000_1000, 32'h0000_00F0, 32'h0,        32'hFFFF_FFF0, 1, 0);

        for (int i = 0; i < 3; i++) begin
            enW = 1'b0;
            randomize_m();
            sb.push_back(last);
            edge_and_check("hold");
        end

        enW = 1'b1; flushW = 1'b1;
        validM = 1'b1; regwriteM = 1'b1; resultsrcM = 2'b00; rdM = 5'd11; aluresultM = 32'h55;
        sb.push_back('{valid: 1'b0, rw: 1'b0, mis: 1'b0, rd: 5'd0, res: 32'd0, chk_data: 1'b0});
        edge_and_check("flush_en");

        send("pre_rst", 1, 1, 2'b00, 3'b000, 5'd12, 32'h0000_0ABC, 32'h0, 32'h0, 32'h0000_0ABC, 1, 0);
        validM = 1'b1; regwriteM = 1'b1; rdM = 5'd13; aluresultM = 32'h777;
        rst = 1'b1;
        sb.push_back('{valid: 1'b0, rw: 1'b0, mis: 1'b0, rd: 5'd0, res: 32'd0, chk_data: 1'b1});
        edge_and_check("mid_rst");
        rst = 1'b0;

`ifdef WB_RETIRE_CNT_EN
        reset_cycle("cnt_rst");
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i == 3 || i == 7 || i == 11)
                send("cnt_bub", 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
            else
                send("cnt_ins", 1, 1, 2'b00, 3'b000, 5'(i + 1), 32'(i), 32'h0, 32'h0, 32'(i), 1, 0);
        end
        send("cnt_tail", 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        chk("instret_10", instretW, 64'd10);

        force dut.instret_q = '1;
        #1;
        release dut.instret_q;
        exp_cnt = '1;
        send("wrap_ins", 1, 1, 2'b00, 3'b000, 5'd3, 32'h99, 32'h0, 32'h0, 32'h99, 1, 0);
        send("wrap_bub", 0, 0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);
        chk("instret_wrap", instretW, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the pipelined RISC-V core: the MEM/WB pipeline register plus load-data alignment/extension and result selection. It is the producer of the register-file write port and of the WB→ID bypass data (`regwriteW`, `rdW`, `resultW`) consumed by the decode stage. It also flags misaligned loads and, optionally, counts retired instructions.

## Interface
Parameters:
- `XLEN`, 32, data width
- `CNT_W`, 64, retire counter width (used only with `WB_RETIRE_CNT_EN`)

Ports:
- `CLK`  in  1  core clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `enW`  in  1  MEM/WB register load enable; 0 = hold
- `flushW`  in  1  load a bubble into MEM/WB
- `validM`  in  1  MEM-stage slot holds a real instruction
- `regwriteM`  in  1  instruction writes rd
- `resultsrcM`  in  2  00 ALU, 01 load, 10 PC+4, 11 ALU
- `addressingmodeM`  in  3  load type, funct3 encoding
- `rdM`  in  5  destination register
- `aluresultM`  in  XLEN  ALU result / load address
- `readdataM`  in  XLEN  raw aligned data-memory word
- `pcplus4M`  in  XLEN  link value
- `regwriteW`  out  1  register-file write enable
- `rdW`  out  5  write address
- `resultW`  out  XLEN  write data
- `validW`  out  1  WB slot valid
- `misalignW`  out  1  WB slot is a misaligned load
- `instretW`  out  CNT_W  retired-instruction count (`WB_RETIRE_CNT_EN` only)

## Operation
- MEM/WB register holds: valid, regwrite, resultsrc, addressingmode, rd, aluresult, readdata, pcplus4.
- Update priority each rising edge: `rst` > `flushW` > `enW` > hold.
  - rst: all fields 0.
  - flushW: valid=0, regwrite=0; data fields don't-care (cleared to 0).
  - enW: capture all M inputs.
- Load extension from registered `aluresult[1:0]` (offset) and addressing mode:
  - 000 LB: byte at offset, sign-extend; 100 LBU: zero-extend.
  - 001 LH: half at offset[1], sign-extend; 101 LHU: zero-extend.
  - 010 LW: full word.
  - other codes: full word, not flagged.
- Misaligned: load (resultsrc=01) with LH/LHU and offset[0]=1, or LW with offset≠0.
- `resultW`: resultsrc 01 → extended load, 10 → pcplus4, 00/11 → aluresult.
- `regwriteW` = valid & regwrite & (rd≠0) & ~misaligned.
- `misalignW` = valid & misaligned.
- `rdW` = registered rd, passed through unmodified.

## Timing
- Latency: M inputs visible on W outputs one cycle after the capturing edge.
- `resultW`, `regwriteW`, `misalignW` are combinational from the MEM/WB register, stable for the whole cycle, so the register file writes and decode bypasses in the same cycle.
- Reset values: `regwriteW`=0, `rdW`=0, `resultW`=0, `validW`=0, `misalignW`=0, `instretW`=0.
- `flushW` and `enW` both high: flush wins.
- `enW`=0: outputs hold, so the same write is presented again. The register-file write is idempotent.
- Reset asserted mid-stream: the pending WB write is dropped on that edge.

## Configuration
- `WB_RETIRE_CNT_EN` defined: adds a CNT_W-bit counter. It increments on every edge where `validW`=1 and `misalignW`=0, and wraps modulo 2^CNT_W. Reset clears it to 0.
- Not defined: no counter logic, and `instretW` is tied to 0. The port remains so the interface is identical in both builds.

## Structure
- Shared package `pipe_pkg` holds:
  - `resultsrc_t` enum: ALU, LOAD, PC4, ALU_ALT.
  - `addrmode_t` enum: LB, LH, LW, LBU, LHU.
  - `mem_wb_t` packed struct for the pipeline register.
- One sub-module, `load_extend`: combinational, inputs word + offset + addrmode, outputs extended value + misaligned flag.

## Test plan
- Reset: hold `rst` for 2 cycles with random M inputs → all outputs 0, including `instretW`=0.
- LB, `aluresultM`=0x1003, `readdataM`=0x80FF_1234, rd=5 → next cycle `resultW`=0xFFFF_FF80, `regwriteW`=1, `rdW`=5. Same stimulus as LBU → `resultW`=0x0000_0080.
- LH with `aluresultM`=0x1001 → `misalignW`=1, `regwriteW`=0, counter not incremented. LHU with offset 2 and word 0xBEEF_0000 → `resultW`=0x0000_BEEF.
- JAL: resultsrc=10, `pcplus4M`=0x0000_0104, rd=1 → `resultW`=0x104. Same instruction with rd=0 → `regwriteW`=0, `validW`=1.
- `enW`=0 for 3 cycles → outputs frozen. Assert `flushW` and `enW` together → next cycle `validW`=0, `regwriteW`=0.
- With `WB_RETIRE_CNT_EN`: 10 valid non-misaligned instructions interleaved with 3 bubbles → `instretW`=10. Preload counter to 2^CNT_W−1 via a bench force, retire one → `instretW` wraps to 0.
